// File: rtl/prog_loader.sv
// ---------------------------------------------------------------------------
// prog_loader
//
// Streams a boot image into the core's instruction and data BRAMs while the
// CPU is held stalled. The image is a series of segments. Each segment is a
// header word, a base-address word and N payload words. Payload word k lands
// at byte address base + 4k of the BRAM that the header selects. The loader
// releases the CPU after the segment flagged "last". A misaligned or
// oversized segment parks the loader in ERR until reset.
//
// Header word: [DATA_WIDTH-1] target (0 = instruction BRAM, 1 = data BRAM)
//              [DATA_WIDTH-2] last segment
//              [CNT_WIDTH-1:0] payload word count N
//
// Ports
//   clk        in   system clock, rising edge
//   rst        in   asynchronous active-high reset
//   start      in   reload request pulse, honoured only in DONE
//   s_valid    in   stream word valid
//   s_data     in   stream word (header, base or payload)
//   s_ready    out  stream word accepted on s_valid && s_ready
//   i_w_addr   out  instruction BRAM write byte address
//   i_w_dat    out  instruction BRAM write data
//   i_w_enb    out  instruction BRAM write enable (one cycle per word)
//   d_w_addr   out  data BRAM write byte address
//   d_w_dat    out  data BRAM write data
//   d_w_enb    out  data BRAM write enable (one cycle per word)
//   cpu_stall  out  holds the core's pc while the image is loading
//   init_done  out  loading finished; core owns the data BRAM write port
//   err        out  malformed segment seen; cleared only by rst
// ---------------------------------------------------------------------------
module prog_loader #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  s_valid,
  input  logic [DATA_WIDTH-1:0] s_data,
  output logic                  s_ready,
  output logic [ADDR_WIDTH-1:0] i_w_addr,
  output logic [DATA_WIDTH-1:0] i_w_dat,
  output logic                  i_w_enb,
  output logic [ADDR_WIDTH-1:0] d_w_addr,
  output logic [DATA_WIDTH-1:0] d_w_dat,
  output logic                  d_w_enb,
  output logic                  cpu_stall,
  output logic                  init_done,
  output logic                  err
);

  typedef enum logic [2:0] {
    ST_HDR,
    ST_BASE,
    ST_LOAD,
    ST_DONE,
    ST_ERR
  } state_t;

  // The range check must hold the largest word index plus the largest
  // count without wrapping, so it is one bit wider than either operand.
  localparam int CHK_W = ((CNT_WIDTH > ADDR_WIDTH) ? CNT_WIDTH : ADDR_WIDTH) + 1;
  localparam logic [CHK_W-1:0] DEPTH_WORDS =
    {{(CHK_W-1){1'b0}}, 1'b1} << (ADDR_WIDTH - 2);

  state_t                r_state;
  state_t                w_next;
  logic                  r_target;   // 1 = data BRAM
  logic                  r_last;
  logic [CNT_WIDTH-1:0]  r_cnt;      // header N, then payload words still due
  logic [ADDR_WIDTH-1:0] r_addr;     // base, then address of next payload word

  logic                  w_accept;
  logic [CHK_W-1:0]      w_base_word;
  logic [CHK_W-1:0]      w_cnt_ext;
  logic [CHK_W-1:0]      w_end_word;
  logic                  w_misaligned;
  logic                  w_overflow;

  assign w_accept     = s_valid && s_ready;
  assign w_base_word  = {{(CHK_W-ADDR_WIDTH+2){1'b0}}, s_data[ADDR_WIDTH-1:2]};
  assign w_cnt_ext    = {{(CHK_W-CNT_WIDTH){1'b0}}, r_cnt};
  assign w_end_word   = w_base_word + w_cnt_ext;
  assign w_misaligned = (s_data[1:0] != 2'b00);
  // A segment may end exactly at the top of the BRAM; one word past is out.
  assign w_overflow   = (w_end_word > DEPTH_WORDS);

  // State register.
  // NOTE: clocked state uses non-blocking (<=) so every flop samples its
  // inputs before any of them update on the same edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_HDR;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state and state-decoded outputs.
  // NOTE: every output gets a default before the case so no path leaves one
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    w_next    = r_state;
    s_ready   = 1'b0;
    cpu_stall = 1'b1;
    init_done = 1'b0;
    err       = 1'b0;
    case (r_state)
      ST_HDR: begin
        s_ready = 1'b1;
        if (w_accept) begin
          w_next = ST_BASE;
        end
      end
      ST_BASE: begin
        s_ready = 1'b1;
        if (w_accept) begin
          if (w_misaligned || w_overflow) begin
            w_next = ST_ERR;
          end else if (r_cnt == '0) begin
            // Empty segment: nothing to write, move straight on.
            w_next = r_last ? ST_DONE : ST_HDR;
          end else begin
            w_next = ST_LOAD;
          end
        end
      end
      ST_LOAD: begin
        s_ready = 1'b1;
        if (w_accept && (r_cnt == CNT_WIDTH'(1))) begin
          w_next = r_last ? ST_DONE : ST_HDR;
        end
      end
      ST_DONE: begin
        cpu_stall = 1'b0;
        init_done = 1'b1;
        if (start) begin
          w_next = ST_HDR;
        end
      end
      ST_ERR: begin
        err = 1'b1;
      end
      default: begin
        w_next = ST_HDR;
      end
    endcase
  end

  // Segment bookkeeping and the registered BRAM write ports. A word accepted
  // in LOAD appears on the selected port for exactly the following cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_target <= 1'b0;
      r_last   <= 1'b0;
      r_cnt    <= '0;
      r_addr   <= '0;
      i_w_addr <= '0;
      i_w_dat  <= '0;
      i_w_enb  <= 1'b0;
      d_w_addr <= '0;
      d_w_dat  <= '0;
      d_w_enb  <= 1'b0;
    end else begin
      i_w_enb <= 1'b0;
      d_w_enb <= 1'b0;
      if (w_accept) begin
        case (r_state)
          ST_HDR: begin
            r_target <= s_data[DATA_WIDTH-1];
            r_last   <= s_data[DATA_WIDTH-2];
            r_cnt    <= s_data[CNT_WIDTH-1:0];
          end
          ST_BASE: begin
            r_addr <= s_data[ADDR_WIDTH-1:0];
          end
          ST_LOAD: begin
            r_cnt  <= r_cnt - CNT_WIDTH'(1);
            // Wraps only after the final word of a segment that ends at the
            // top of the BRAM, and that value is never used.
            r_addr <= r_addr + ADDR_WIDTH'(4);
            if (r_target) begin
              d_w_enb  <= 1'b1;
              d_w_addr <= r_addr;
              d_w_dat  <= s_data;
            end else begin
              i_w_enb  <= 1'b1;
              i_w_addr <= r_addr;
              i_w_dat  <= s_data;
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// ---------------------------------------------------------------------------
// tb_prog_loader
//
// Self-checking bench for prog_loader. A segment-level reference model tracks
// which part of the stream is expected next (header, base, payload, done,
// error) and computes each write address as base + 4k with plain integer
// arithmetic. A compare process checks every DUT output against the model on
// each falling edge. Directed scenarios pin the model with literal
// expectations. A randomized phase then streams multi-segment images with
// bubbles, stray start pulses, bad segments and mid-load resets.
// ---------------------------------------------------------------------------
module tb_prog_loader;

  localparam int DW    = 32;
  localparam int AW    = 10;
  localparam int CW    = 16;
  localparam int DEPTH = 1 << (AW - 2);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          s_valid = 1'b0;
  logic [DW-1:0] s_data = '0;
  logic          s_ready;
  logic [AW-1:0] i_w_addr;
  logic [DW-1:0] i_w_dat;
  logic          i_w_enb;
  logic [AW-1:0] d_w_addr;
  logic [DW-1:0] d_w_dat;
  logic          d_w_enb;
  logic          cpu_stall;
  logic          init_done;
  logic          err;

  prog_loader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CNT_WIDTH(CW)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .s_valid   (s_valid),
    .s_data    (s_data),
    .s_ready   (s_ready),
    .i_w_addr  (i_w_addr),
    .i_w_dat   (i_w_dat),
    .i_w_enb   (i_w_enb),
    .d_w_addr  (d_w_addr),
    .d_w_dat   (d_w_dat),
    .d_w_enb   (d_w_enb),
    .cpu_stall (cpu_stall),
    .init_done (init_done),
    .err       (err)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ------------------------------------------------------------------------
  // Reference model: what part of the image the stream is expected to carry
  // next, plus the segment fields gathered so far.
  // ------------------------------------------------------------------------
  typedef enum {P_HEADER, P_BASE, P_PAYLOAD, P_FINISHED, P_BROKEN} phase_t;

  phase_t        ph;
  bit            m_tgt;
  bit            m_last;
  int            m_n;
  int            m_k;
  int            m_base;
  logic          exp_ienb;
  logic          exp_denb;
  logic [AW-1:0] exp_iaddr;
  logic [AW-1:0] exp_daddr;
  logic [DW-1:0] exp_idat;
  logic [DW-1:0] exp_ddat;

  function automatic bit seg_fits(input int b, input int n);
    return (b % 4 == 0) && (b / 4 + n <= DEPTH);
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      ph        <= P_HEADER;
      m_tgt     <= 1'b0;
      m_last    <= 1'b0;
      m_n       <= 0;
      m_k       <= 0;
      m_base    <= 0;
      exp_ienb  <= 1'b0;
      exp_denb  <= 1'b0;
      exp_iaddr <= '0;
      exp_daddr <= '0;
      exp_idat  <= '0;
      exp_ddat  <= '0;
    end else begin
      exp_ienb <= 1'b0;
      exp_denb <= 1'b0;
      case (ph)
        P_HEADER: if (s_valid) begin
          m_tgt  <= s_data[DW-1];
          m_last <= s_data[DW-2];
          m_n    <= int'(s_data[CW-1:0]);
          ph     <= P_BASE;
        end
        P_BASE: if (s_valid) begin
          m_base <= int'(s_data[AW-1:0]);
          m_k    <= 0;
          if (!seg_fits(int'(s_data[AW-1:0]), m_n)) ph <= P_BROKEN;
          else if (m_n == 0) ph <= m_last ? P_FINISHED : P_HEADER;
          else ph <= P_PAYLOAD;
        end
        P_PAYLOAD: if (s_valid) begin
          if (m_tgt) begin
            exp_denb  <= 1'b1;
            exp_daddr <= AW'(m_base + 4 * m_k);
            exp_ddat  <= s_data;
          end else begin
            exp_ienb  <= 1'b1;
            exp_iaddr <= AW'(m_base + 4 * m_k);
            exp_idat  <= s_data;
          end
          m_k <= m_k + 1;
          if (m_k + 1 == m_n) ph <= m_last ? P_FINISHED : P_HEADER;
        end
        P_FINISHED: if (start) ph <= P_HEADER;
        default: ;
      endcase
    end
  end

  // ------------------------------------------------------------------------
  // Cycle compare against the model, plus a log of observed writes.
  // ------------------------------------------------------------------------
  typedef struct {
    bit            port;   // 1 = data BRAM
    logic [AW-1:0] addr;
    logic [DW-1:0] dat;
  } wr_t;

  wr_t obs[$];
  bit  cmp_en = 1'b0;

  always @(negedge clk) begin
    if (cmp_en) begin
      check("s_ready",   s_ready,   ph inside {P_HEADER, P_BASE, P_PAYLOAD});
      check("cpu_stall", cpu_stall, ph != P_FINISHED);
      check("init_done", init_done, ph == P_FINISHED);
      check("err",       err,       ph == P_BROKEN);
      check("i_w_enb",   i_w_enb,   exp_ienb);
      check("d_w_enb",   d_w_enb,   exp_denb);
      if (exp_ienb) begin
        check("i_w_addr", i_w_addr, exp_iaddr);
        check("i_w_dat",  i_w_dat,  exp_idat);
      end
      if (exp_denb) begin
        check("d_w_addr", d_w_addr, exp_daddr);
        check("d_w_dat",  d_w_dat,  exp_ddat);
      end
      if (i_w_enb) obs.push_back('{port: 1'b0, addr: i_w_addr, dat: i_w_dat});
      if (d_w_enb) obs.push_back('{port: 1'b1, addr: d_w_addr, dat: d_w_dat});
    end
  end

  // ------------------------------------------------------------------------
  // Stimulus helpers. Every task starts and ends 1 time unit after a rising
  // edge, so inputs never change at an edge.
  // ------------------------------------------------------------------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    s_valid = 1'b0;
    repeat (n) begin
      s_data = $urandom;
      step();
    end
  endtask

  task automatic put(input logic [DW-1:0] d);
    s_valid = 1'b1;
    s_data  = d;
    step();
    s_valid = 1'b0;
    s_data  = $urandom;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic do_reset();
    #2 rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while (!init_done && n < 200) begin
      step();
      n++;
    end
    check("done_timeout", init_done, 1'b1);
  endtask

  task automatic check_wr(input string name, input int idx, input bit port,
                          input logic [AW-1:0] addr, input logic [DW-1:0] dat);
    if (idx < obs.size()) begin
      check({name, "_port"}, obs[idx].port, port);
      check({name, "_addr"}, obs[idx].addr, addr);
      check({name, "_dat"},  obs[idx].dat,  dat);
    end else begin
      check({name, "_missing"}, obs.size(), idx + 1);
    end
  endtask

  // ------------------------------------------------------------------------
  // Main sequence.
  // ------------------------------------------------------------------------
  initial begin
    logic [DW-1:0] w0;
    logic [DW-1:0] w1;
    logic [DW-1:0] w2;
    logic [DW-1:0] w3;

    // Reset values while rst is held.
    step();
    step();
    check("rst_s_ready",   s_ready,   1'b1);
    check("rst_cpu_stall", cpu_stall, 1'b1);
    check("rst_init_done", init_done, 1'b0);
    check("rst_err",       err,       1'b0);
    check("rst_i_w_enb",   i_w_enb,   1'b0);
    check("rst_d_w_enb",   d_w_enb,   1'b0);
    check("rst_i_w_addr",  i_w_addr,  '0);
    check("rst_d_w_dat",   d_w_dat,   '0);
    rst    = 1'b0;
    cmp_en = 1'b1;
    step();

    // Single instruction segment, back-to-back payload.
    obs.delete();
    put(32'h4000_0003); put(32'h0000_0000);
    put(32'hAAAA_0001); put(32'hBBBB_0002); put(32'hCCCC_0003);
    check("t1_init_done", init_done, 1'b1);
    check("t1_cpu_stall", cpu_stall, 1'b0);
    idle(1);
    check("t1_writes", obs.size(), 3);
    check_wr("t1_w0", 0, 1'b0, 10'h000, 32'hAAAA_0001);
    check_wr("t1_w1", 1, 1'b0, 10'h004, 32'hBBBB_0002);
    check_wr("t1_w2", 2, 1'b0, 10'h008, 32'hCCCC_0003);
    pulse_start();

    // Instruction segment followed by the last, data segment.
    obs.delete();
    put(32'h0000_0002); put(32'h0000_0010);
    put(32'h1111_1111); put(32'h2222_2222);
    check("t2_not_done", init_done, 1'b0);
    put(32'hC000_0001); put(32'h0000_000C);
    check("t2_not_done_before_data", init_done, 1'b0);
    put(32'h0000_000A);
    check("t2_init_done", init_done, 1'b1);
    idle(1);
    check("t2_writes", obs.size(), 3);
    check_wr("t2_w0", 0, 1'b0, 10'h010, 32'h1111_1111);
    check_wr("t2_w1", 1, 1'b0, 10'h014, 32'h2222_2222);
    check_wr("t2_w2", 2, 1'b1, 10'h00C, 32'h0000_000A);
    pulse_start();

    // Segment that ends exactly at the top of the BRAM is legal.
    obs.delete();
    put(32'hC000_0002); put(32'h0000_03F8);
    put(32'h5555_0000); put(32'h6666_0000);
    check("tb_top_done", init_done, 1'b1);
    idle(1);
    check_wr("tb_top_w0", 0, 1'b1, 10'h3F8, 32'h5555_0000);
    check_wr("tb_top_w1", 1, 1'b1, 10'h3FC, 32'h6666_0000);
    pulse_start();

    // One word past the top: ERR, nothing written, stream refused.
    obs.delete();
    put(32'h0000_0002); put(32'h0000_03FC);
    check("t3_err", err, 1'b1);
    check("t3_s_ready", s_ready, 1'b0);
    put(32'hDEAD_BEEF); put(32'hFEED_F00D);
    pulse_start();
    check("t3_err_held", err, 1'b1);
    check("t3_no_writes", obs.size(), 0);
    do_reset();

    // Misaligned base, then reset recovers.
    put(32'h4000_0001); put(32'h0000_0006);
    check("t4_err", err, 1'b1);
    do_reset();
    check("t4_err_cleared", err, 1'b0);
    check("t4_cpu_stall", cpu_stall, 1'b1);
    check("t4_s_ready", s_ready, 1'b1);

    // Bubbles inside a payload, then a reload request.
    obs.delete();
    put(32'h4000_0004); put(32'h0000_0020);
    put(32'hA0A0_0000); put(32'hA1A1_0001);
    idle(2);
    put(32'hA2A2_0002); put(32'hA3A3_0003);
    check("t5_init_done", init_done, 1'b1);
    idle(1);
    check("t5_writes", obs.size(), 4);
    check_wr("t5_w0", 0, 1'b0, 10'h020, 32'hA0A0_0000);
    check_wr("t5_w1", 1, 1'b0, 10'h024, 32'hA1A1_0001);
    check_wr("t5_w2", 2, 1'b0, 10'h028, 32'hA2A2_0002);
    check_wr("t5_w3", 3, 1'b0, 10'h02C, 32'hA3A3_0003);
    pulse_start();
    check("t5_restall", cpu_stall, 1'b1);
    check("t5_ready", s_ready, 1'b1);

    // Reset part-way through a payload, then a clean segment.
    put(32'h0000_0004); put(32'h0000_0040);
    put(32'h7777_0000); put(32'h7777_0001);
    #2 rst = 1'b1;
    #1;
    check("t6_rst_i_w_enb", i_w_enb, 1'b0);
    check("t6_rst_i_w_addr", i_w_addr, '0);
    check("t6_rst_s_ready", s_ready, 1'b1);
    check("t6_rst_cpu_stall", cpu_stall, 1'b1);
    step();
    rst = 1'b0;
    obs.delete();
    put(32'h4000_0001); put(32'h0000_0080); put(32'h9999_0000);
    check("t6_done", init_done, 1'b1);
    idle(1);
    check_wr("t6_w0", 0, 1'b0, 10'h080, 32'h9999_0000);
    pulse_start();

    // Randomized images.
    for (int img = 0; img < 60; img++) begin
      int  nseg;
      bit  aborted;
      nseg    = $urandom_range(1, 3);
      aborted = 1'b0;
      for (int s = 0; s < nseg && !aborted; s++) begin
        int            n;
        int            idx;
        int            mode;
        int            base;
        bit            tgt;
        logic [DW-1:0] hdr;
        logic [DW-1:0] bw;
        n    = $urandom_range(0, 6);
        tgt  = 1'($urandom);
        mode = $urandom_range(0, 19);
        idx  = $urandom_range(0, DEPTH - n);
        base = idx * 4;
        if (mode == 0) base = base | $urandom_range(1, 3);
        else if (mode == 1 && n >= 2) base = $urandom_range(DEPTH - n + 1, DEPTH - 1) * 4;
        hdr = {tgt, 1'(s == nseg - 1), 14'($urandom), 16'(n)};
        bw  = {22'($urandom), 10'(base)};
        start = 1'($urandom_range(0, 9) == 0);
        put(hdr);
        start = 1'b0;
        put(bw);
        if (!seg_fits(base, n)) begin
          put($urandom);
          idle(1);
          do_reset();
          aborted = 1'b1;
        end else begin
          for (int k = 0; k < n && !aborted; k++) begin
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
            start = 1'($urandom_range(0, 7) == 0);
            put($urandom);
            start = 1'b0;
            if ($urandom_range(0, 39) == 0) begin
              do_reset();
              aborted = 1'b1;
            end
          end
        end
      end
      if (!aborted) begin
        wait_done();
        idle($urandom_range(0, 3));
        pulse_start();
      end
    end

    idle(2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/prog_loader.md
PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 Parameter DATA_WIDTH, default 32, width of the stream word and of both BRAM write-data buses.
REQ-002 Parameter ADDR_WIDTH, default 10, width of the BRAM byte addresses; BRAM depth is 2^(ADDR_WIDTH-2) words.
REQ-003 Parameter CNT_WIDTH, default 16, width of the header word-count field.
REQ-004 The block SHALL have one clock, clk; reset is asynchronous and active-high, named rst.
REQ-005 clk  input  1  system clock, all logic on rising edge.
REQ-006 rst  input  1  asynchronous active-high reset.
REQ-007 start  input  1  one-cycle pulse requesting a reload; honoured only in DONE.
REQ-008 s_valid  input  1  stream word valid.
REQ-009 s_data  input  DATA_WIDTH  stream word (header or payload).
REQ-010 s_ready  output  1  stream word accepted when s_valid && s_ready at a rising edge.
REQ-011 i_w_addr / i_w_dat / i_w_enb  output  ADDR_WIDTH / DATA_WIDTH / 1  instruction BRAM write port.
REQ-012 d_w_addr / d_w_dat / d_w_enb  output  ADDR_WIDTH / DATA_WIDTH / 1  data BRAM write port.
REQ-013 cpu_stall  output  1  drives pc stall; high whenever state is not DONE.
REQ-014 init_done  output  1  high only in DONE; hands data BRAM write control to the core.
REQ-015 err  output  1  high only in ERR.

Function
REQ-016 States: HDR, BASE, LOAD, DONE, ERR; reset state HDR.
REQ-017 Header word fields: [DATA_WIDTH-1] target (0 instruction, 1 data); [DATA_WIDTH-2] last segment; [CNT_WIDTH-1:0] word count N.
REQ-018 HDR: s_ready=1; accepted header latches target, last, N; next state BASE.
REQ-019 BASE: s_ready=1; accepted word latches base byte address = s_data[ADDR_WIDTH-1:0]; bits [1:0] non-zero -> ERR.
REQ-020 BASE: (base>>2)+N > 2^(ADDR_WIDTH-2), computed at ADDR_WIDTH+1 bits minimum (no wrap) -> ERR.
REQ-021 BASE with N=0: next state DONE if last=1, else HDR; no writes issued.
REQ-022 LOAD: s_ready=1; k-th accepted payload word (k=0..N-1) written to address base+4k of the selected BRAM.
REQ-023 Write port registered: word accepted at edge E -> w_enb=1, w_addr, w_dat valid for exactly the cycle after E; w_enb=0 otherwise; unselected port w_enb stays 0.
REQ-024 s_valid low in LOAD: no write, no counter advance, state held (arbitrary bubbles allowed).
REQ-025 After N-th payload word: next state DONE if last=1, else HDR.
REQ-026 DONE: s_ready=0, cpu_stall=0, init_done=1; start=1 -> HDR, cpu_stall=1 the next cycle.
REQ-027 ERR: s_ready=0, cpu_stall=1, all w_enb=0; exit only via rst.
REQ-028 start outside DONE ignored; s_valid in DONE/ERR ignored (no acceptance).

Reset
REQ-029 rst high asynchronously forces state HDR, s_ready=1, cpu_stall=1, init_done=0, err=0, all w_enb=0, all w_addr/w_dat=0, count and base registers 0.
REQ-030 rst asserted mid-LOAD aborts the segment; already-written BRAM words are not undone; stream resumes with a header.

Verification
REQ-031 Header 0x4000_0003, base 0x0, words A,B,C back-to-back -> i_w_enb pulses 3 cycles, addrs 0x0,0x4,0x8, data A,B,C; d_w_enb never 1; DONE next cycle, cpu_stall=0, init_done=1.
REQ-032 Header 0x0000_0002 base 0x10 (instr), then 0xC000_0001 base 0xC, word 0x0000000A -> instr 0x10,0x14 written, then data 0xC=0x0000000A; init_done only after the data write.
REQ-033 Base 0x3FC, N=2, ADDR_WIDTH=10 -> ERR, err=1, no write issued, s_ready=0 until rst.
REQ-034 Base 0x6 -> ERR; rst pulse -> HDR, err=0, cpu_stall=1.
REQ-035 N=4 with s_valid dropped 2 cycles between words 1 and 2 -> exactly 4 writes, contiguous addresses; start pulse in DONE -> cpu_stall=1, HDR.
REQ-036 rst asserted after 2 of 4 payload words -> outputs at reset values immediately; next header loads normally.
